mult_seq: RTL and testbench



---
 rtl/mult_seq.sv | 137 +++++++++++++
 tb/tb_mult_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq
// Brief    : Sequential shift-and-add multiplier, one multiplier bit per clock,
//            full 2*WIDTH-bit product, start/busy/done handshake.
//            Define MULT_SIGNED_EN to honour signed_in (sign-magnitude).
// Revision : 1.0 - initial release
// ============================================================================
module mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 signed_in,
    input  logic                 start_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [2*WIDTH-1:0]   y_out
);

    localparam int c_CTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CTR_W-1:0] c_CTR_LAST = c_CTR_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WORK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CTR_W-1:0]   r_ctr;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic [2*WIDTH-1:0]   r_y;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_partial;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_result;

`ifdef MULT_SIGNED_EN
    logic                 r_sign;
    logic                 w_sign;

    // Negating -2^(WIDTH-1) in WIDTH bits yields 2^(WIDTH-1) as an unsigned magnitude.
    assign w_sign     = signed_in & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
    assign w_mag_a    = (signed_in && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
    assign w_mag_b    = (signed_in && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;
    assign w_result   = r_sign ? (~w_acc_next + 1'b1) : w_acc_next;
`else
    logic                 w_unused_signed;

    assign w_unused_signed = signed_in;
    assign w_mag_a    = a_in;
    assign w_mag_b    = b_in;
    assign w_result   = w_acc_next;
`endif

    assign w_accept   = (r_state == S_IDLE) && start_in;
    assign w_last     = (r_ctr == c_CTR_LAST);
    assign w_partial  = r_mag_b[r_ctr] ? ({{WIDTH{1'b0}}, r_mag_a} << r_ctr) : '0;
    assign w_acc_next = r_acc + w_partial;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy_out     = 1'b0;
        done_out     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_state_next = S_WORK;
                end
            end
            S_WORK: begin
                busy_out = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy_out     = 1'b1;
                done_out     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ctr   <= '0;
            r_acc   <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_y     <= '0;
`ifdef MULT_SIGNED_EN
            r_sign  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_ctr   <= '0;
            r_acc   <= '0;
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
`ifdef MULT_SIGNED_EN
            r_sign  <= w_sign;
`endif
        end else if (r_state == S_WORK) begin
            r_acc <= w_acc_next;
            r_ctr <= r_ctr + c_CTR_W'(1);
            // The product register only moves at completion; no partial sums leak out.
            if (w_last) begin
                r_y <= w_result;
            end
        end
    end

    assign y_out = r_y;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq
// Brief    : Scoreboard bench for mult_seq (WIDTH=8 main instance, WIDTH=16 aux).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_seq;

    localparam int WIDTH = 8;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic [WIDTH-1:0]   a_in = '0;
    logic [WIDTH-1:0]   b_in = '0;
    logic               signed_in = 1'b0;
    logic               start_in = 1'b0;
    logic               busy_out;
    logic               done_out;
    logic [2*WIDTH-1:0] y_out;

    logic [15:0]        a16 = '0;
    logic [15:0]        b16 = '0;
    logic               s16 = 1'b0;
    logic               start16 = 1'b0;
    logic               busy16;
    logic               done16;
    logic [31:0]        y16;

    int                 n_tests = 0;
    int                 n_fail = 0;
    int                 cyc = 0;
    int                 issue_cyc = 0;
    logic [15:0]        exp_q[$];

    mult_seq #(.WIDTH(WIDTH)) u_dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .signed_in (signed_in),
        .start_in  (start_in),
        .busy_out  (busy_out),
        .done_out  (done_out),
        .y_out     (y_out)
    );

    mult_seq #(.WIDTH(16)) u_dut16 (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .a_in      (a16),
        .b_in      (b16),
        .signed_in (s16),
        .start_in  (start16),
        .busy_out  (busy16),
        .done_out  (done16),
        .y_out     (y16)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint sa;
        longint sb;
        sa = longint'(a);
        sb = longint'(b);
`ifdef MULT_SIGNED_EN
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
`else
        if (s) begin
            sa = longint'(a);
        end
`endif
        return 16'(sa * sb);
    endfunction

    // Completion monitor: every done pulse must match the oldest outstanding op.
    always @(negedge clk_in) begin
        if (done_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(done_out), 64'd0);
            end else begin
                check("product", 64'(y_out), 64'(exp_q.pop_front()));
                check("latency", 64'(cyc - issue_cyc), 64'(WIDTH));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_out && n < 40) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (busy_out) check("idle_timeout", 64'(busy_out), 64'd0);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input bit track);
        a_in      = a;
        b_in      = b;
        signed_in = s;
        start_in  = 1'b1;
        @(posedge clk_in); #1;
        start_in  = 1'b0;
        a_in      = 8'h5A;
        b_in      = 8'hC3;
        signed_in = ~s;
        if (track) begin
            exp_q.push_back(model(a, b, s));
            issue_cyc = cyc;
        end
    endtask

    initial begin
        int nbusy;
        int rise1;
        int rise2;
        bit found;
        logic prev;

        #3 rst_in = 1'b1;
        #1;
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_done", 64'(done_out), 64'd0);
        check("rst_y", 64'(y_out), 64'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in) rst_in = 1'b0;

        // Full-scale unsigned, also measuring the busy window.
        issue(8'hFF, 8'hFF, 1'b0, 1'b1);
        nbusy = 0;
        while (busy_out && nbusy < 40) begin
            nbusy++;
            @(posedge clk_in); #1;
        end
        check("busy_cycles", 64'(nbusy), 64'd9);
        check("y_hold", 64'(y_out), 64'hFE01);

        // Abort mid-operation after four WORK edges.
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (4) @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("abort_busy", 64'(busy_out), 64'd0);
        check("abort_y", 64'(y_out), 64'd0);
        @(negedge clk_in) rst_in = 1'b0;
        issue(8'h0D, 8'h0B, 1'b0, 1'b1);
        wait_idle();

        issue(8'hFD, 8'h05, 1'b1, 1'b1);
        wait_idle();
        issue(8'h80, 8'h80, 1'b1, 1'b1);
        wait_idle();
        issue(8'hFD, 8'h05, 1'b0, 1'b1);
        wait_idle();
        issue(8'h7F, 8'h80, 1'b1, 1'b1);
        wait_idle();

        // Start held high; operands change during WORK.
        a_in = 8'd7; b_in = 8'd9; signed_in = 1'b0; start_in = 1'b1;
        @(posedge clk_in); #1;
        rise1 = cyc;
        exp_q.push_back(model(8'd7, 8'd9, 1'b0));
        issue_cyc = cyc;
        a_in = 8'd3; b_in = 8'd3;
        prev = 1'b1; found = 1'b0; rise2 = rise1;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk_in); #1;
            if (busy_out && !prev) begin
                found = 1'b1;
                rise2 = cyc;
                exp_q.push_back(model(8'd3, 8'd3, 1'b0));
                issue_cyc = cyc;
                start_in = 1'b0;
            end
            prev = busy_out;
        end
        start_in = 1'b0;
        check("held_accept", 64'(found), 64'd1);
        check("interval", 64'(rise2 - rise1), 64'd10);
        wait_idle();

        // WIDTH=16 instance: no early done, no intermediate y.
        a16 = 16'hFFFF; b16 = 16'hFFFF; s16 = 1'b0; start16 = 1'b1;
        @(posedge clk_in); #1;
        start16 = 1'b0;
        repeat (15) begin
            @(posedge clk_in); #1;
        end
        check("w16_early_done", 64'(done16), 64'd0);
        check("w16_y_hold", 64'(y16), 64'd0);
        @(posedge clk_in); #1;
        check("w16_done", 64'(done16), 64'd1);
        check("w16_y", 64'(y16), 64'hFFFE0001);

        for (int k = 0; k < 24; k++) begin
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b1);
            wait_idle();
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
